screen_sequencer: RTL



---
 rtl/screen_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/screen_sequencer.sv
// Game-flow controller: steps title -> alternating trace/message screens -> scoreboard,
// with its own 1 s prescaler, per-screen second counter, start/skip/pause control.
module screen_sequencer #(
  parameter int CYCLES_PER_SEC = 50000000,
  parameter int TITLE_SECS     = 5,
  parameter int TRACE_SECS     = 20,
  parameter int MSG_SECS       = 10,
  parameter int SNITCH_START   = 8,
  parameter int SNITCH_END     = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        skip,
  input  logic        pause,
  input  logic [5:0]  total_screens,
  output logic [4:0]  curr_screen,
  output logic [1:0]  screen_type,
  output logic [5:0]  sec_in_screen,
  output logic [31:0] game_secs,
  output logic        screen_change,
  output logic        snitch_powerup,
  output logic        end_of_game
);

  localparam int PW = $clog2(CYCLES_PER_SEC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CYCLES_PER_SEC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TITLE,
    S_TRACE,
    S_MSG,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    tot_q, tot_d;
  logic [4:0]    curr_q, curr_d;
  logic [1:0]    type_q, type_d;
  logic [5:0]    sec_q, sec_d;
  logic [31:0]   game_q, game_d;
  logic          chg_q, chg_d;
  logic          snitch_q, snitch_d;
  logic          eog_q, eog_d;

  logic          running;
  logic          tick;
  logic          advance;
  logic [5:0]    next_scr;
  logic [4:0]    new_tot;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [4:0] clamp_tot(input logic [5:0] n);
    return n[5] ? 5'd31 : n[4:0];
  endfunction

  function automatic logic [5:0] dur_of(input state_t s);
    case (s)
      S_TITLE: return 6'(TITLE_SECS);
      S_TRACE: return 6'(TRACE_SECS);
      default: return 6'(MSG_SECS);
    endcase
  endfunction

  function automatic logic [1:0] type_of(input state_t s);
    case (s)
      S_TITLE: return 2'd1;
      S_TRACE: return 2'd2;
      S_MSG:   return 2'd3;
      S_DONE:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    tot_d    = tot_q;
    curr_d   = curr_q;
    sec_d    = sec_q;
    game_d   = game_q;
    chg_d    = 1'b0;
    running  = (state_q == S_TITLE) || (state_q == S_TRACE) || (state_q == S_MSG);
    tick     = running && !pause && (presc_q == PRESC_MAX);
    advance  = running && !pause && (skip || (tick && (sec_q == dur_of(state_q) - 6'd1)));
    next_scr = {1'b0, curr_q} + 6'd1;
    new_tot  = clamp_tot(total_screens);

    if (!running) begin
      // IDLE and DONE share start handling; a start in DONE begins a fresh game
      if (start) begin
        tot_d   = new_tot;
        curr_d  = 5'd1;
        sec_d   = '0;
        game_d  = '0;
        presc_d = '0;
        chg_d   = 1'b1;
        state_d = (new_tot <= 5'd1) ? S_DONE : S_TITLE;
      end
    end else if (!pause) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        sec_d  = sec_q + 6'd1;
        game_d = sat_inc32(game_q);
      end
      // A skip coinciding with the final tick still yields a single advance
      if (advance) begin
        presc_d = '0;
        sec_d   = '0;
        chg_d   = 1'b1;
        if (next_scr >= {1'b0, tot_q}) begin
          curr_d  = tot_q;
          state_d = S_DONE;
        end else begin
          curr_d  = next_scr[4:0];
          state_d = next_scr[0] ? S_MSG : S_TRACE;
        end
      end
    end

    type_d   = type_of(state_d);
    eog_d    = (state_d == S_DONE);
    snitch_d = (state_d == S_TRACE) && (sec_d >= 6'(SNITCH_START)) && (sec_d < 6'(SNITCH_END));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      tot_q    <= '0;
      curr_q   <= '0;
      type_q   <= '0;
      sec_q    <= '0;
      game_q   <= '0;
      chg_q    <= 1'b0;
      snitch_q <= 1'b0;
      eog_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      tot_q    <= tot_d;
      curr_q   <= curr_d;
      type_q   <= type_d;
      sec_q    <= sec_d;
      game_q   <= game_d;
      chg_q    <= chg_d;
      snitch_q <= snitch_d;
      eog_q    <= eog_d;
    end
  end

  assign curr_screen    = curr_q;
  assign screen_type    = type_q;
  assign sec_in_screen  = sec_q;
  assign game_secs      = game_q;
  assign screen_change  = chg_q;
  assign snitch_powerup = snitch_q;
  assign end_of_game    = eog_q;

endmodule
